// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared types and constants for the switch ingress framer
package sw_pkg;

    localparam int SW_CNT_W     = 16;
    localparam int SW_W_WIDTH   = 8;
    localparam int SW_NUM_PORTS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } ingress_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with increment enable
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count up on each enabled cycle, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sw_ingress.sv
// rtl/sw_ingress.sv - ingress framer driving the shared port bus; stats gated by SW_INGRESS_STATS_EN
module sw_ingress
    import sw_pkg::*;
#(
    parameter int NUM_PORTS = SW_NUM_PORTS,
    parameter int W_WIDTH   = SW_W_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [W_WIDTH-1:0]   in_data,
    output logic                 in_ready,
    input  logic [NUM_PORTS-1:0] port_free,
    output logic                 sw_en,
    output logic [W_WIDTH-1:0]   port_addr,
    output logic [W_WIDTH-1:0]   port_data,
    output logic [SW_CNT_W-1:0]  pkt_cnt,
    output logic [SW_CNT_W-1:0]  drop_cnt
);

    ingress_state_t     r_state;
    logic [W_WIDTH-1:0] r_port_addr;
    logic [W_WIDTH-1:0] r_rem;
    // Set while a dropped packet still owes its length byte
    logic               r_need_len;

    logic w_sel_free;
    logic w_accept;
    logic w_dest_ok;

    // Pick the not-full flag of the port the packet is headed to
    always_comb begin
        w_sel_free = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_port_addr == W_WIDTH'(i)) begin
                w_sel_free = port_free[i];
            end
        end
    end

    assign w_dest_ok = (in_data < W_WIDTH'(NUM_PORTS));
    assign in_ready  = (r_state == PAYLOAD) ? w_sel_free : 1'b1;
    assign w_accept  = in_valid & in_ready;
    // Zero-latency payload path: the port captures on the same edge we accept
    assign sw_en     = (r_state == PAYLOAD) & w_accept;
    assign port_data = in_data;
    assign port_addr = r_port_addr;

    // Framing FSM: header, length, then payload or discard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_port_addr <= '0;
            r_rem       <= '0;
            r_need_len  <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                IDLE: begin
                    r_port_addr <= in_data;
                    if (w_dest_ok) begin
                        r_state <= LEN;
                    end else begin
                        r_state    <= DROP;
                        r_need_len <= 1'b1;
                    end
                end
                LEN: begin
                    r_rem   <= in_data;
                    r_state <= (in_data == '0) ? IDLE : PAYLOAD;
                end
                PAYLOAD: begin
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == W_WIDTH'(1)) begin
                        r_state <= IDLE;
                    end
                end
                DROP: begin
                    if (r_need_len) begin
                        r_rem      <= in_data;
                        r_need_len <= 1'b0;
                        if (in_data == '0) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == W_WIDTH'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SW_INGRESS_STATS_EN
    logic w_pkt_inc;
    logic w_drop_inc;

    // A packet completes on its last accepted byte (the length byte when L=0)
    assign w_pkt_inc  = w_accept &
                        (((r_state == LEN) && (in_data == '0)) ||
                         ((r_state == PAYLOAD) && (r_rem == W_WIDTH'(1))));
    assign w_drop_inc = w_accept & (r_state == DROP) &
                        ((r_need_len && (in_data == '0)) ||
                         (!r_need_len && (r_rem == W_WIDTH'(1))));

    sat_counter #(.WIDTH(SW_CNT_W)) u_pkt_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_pkt_inc),
        .o_count (pkt_cnt)
    );

    sat_counter #(.WIDTH(SW_CNT_W)) u_drop_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_drop_inc),
        .o_count (drop_cnt)
    );
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_sw_ingress.sv
// tb/tb_sw_ingress.sv - randomized self-checking bench for sw_ingress
module tb_sw_ingress;

`ifdef SW_INGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  port_free;
    logic        sw_en;
    logic [7:0]  port_addr;
    logic [7:0]  port_data;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    int n_vec;
    int n_err;

    // Reference model: frame-level packet and drop tallies
    logic [15:0] m_pkt;
    logic [15:0] m_drop;
    logic [7:0]  pay [0:255];

    sw_ingress #(.NUM_PORTS(4), .W_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .port_free (port_free),
        .sw_en     (sw_en),
        .port_addr (port_addr),
        .port_data (port_data),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one frame byte by byte; every cycle is checked against the frame-level expectation
    task automatic send_frame(input logic [7:0] d, input int len, input int max_bytes,
                              input bit rnd, input int stall_after);
        int         total;
        int         nb;
        int         writes;
        int         stall_left;
        int         budget;
        bit         acc;
        bit         good;
        bit         exp_ready;
        bit         exp_sw;
        logic [7:0] b;
        logic [15:0] e_pkt;
        logic [15:0] e_drop;
        total      = 2 + len;
        nb         = (max_bytes < total) ? max_bytes : total;
        good       = (d < 8'd4);
        writes     = 0;
        stall_left = 0;
        for (int k = 0; k < nb; k++) begin
            b      = (k == 0) ? d : (k == 1) ? 8'(len) : pay[k-2];
            acc    = 1'b0;
            budget = 0;
            while (!acc) begin
                @(negedge clk);
                if (rnd) begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    port_free = 4'($urandom);
                end else begin
                    in_valid  = 1'b1;
                    port_free = 4'hF;
                    if (stall_left > 0 && good) begin
                        port_free[d[1:0]] = 1'b0;
                        stall_left--;
                    end
                end
                in_data = b;
                #1;
                exp_ready = (k >= 2 && good) ? port_free[d[1:0]] : 1'b1;
                exp_sw    = in_valid && exp_ready && (k >= 2) && good;
                n_vec++;
                if (in_ready !== exp_ready) begin
                    n_err++;
                    $display("FAIL in_ready frame d=%0d byte %0d: got %b want %b", d, k, in_ready, exp_ready);
                end
                n_vec++;
                if (sw_en !== exp_sw) begin
                    n_err++;
                    $display("FAIL sw_en frame d=%0d byte %0d: got %b want %b", d, k, sw_en, exp_sw);
                end
                if (k >= 1) begin
                    n_vec++;
                    if (port_addr !== d) begin
                        n_err++;
                        $display("FAIL port_addr byte %0d: got %0d want %0d", k, port_addr, d);
                    end
                end
                if (exp_sw) begin
                    writes++;
                    n_vec++;
                    if (port_data !== b) begin
                        n_err++;
                        $display("FAIL port_data byte %0d: got %h want %h", k, port_data, b);
                    end
                end
                acc = in_valid && exp_ready;
                if (acc && !rnd && stall_after >= 0 && k == 2 + stall_after) stall_left = 2;
                budget++;
                if (budget > 200) begin
                    n_err++;
                    $display("FAIL timeout frame d=%0d byte %0d: got no accept want accept", d, k);
                    acc = 1'b1;
                end
                @(posedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (nb == total) begin
            if (good) m_pkt  = (m_pkt  == 16'hFFFF) ? m_pkt  : m_pkt  + 16'd1;
            else      m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
            #1;
            e_pkt  = STATS ? m_pkt  : 16'd0;
            e_drop = STATS ? m_drop : 16'd0;
            n_vec++;
            if (writes != (good ? len : 0)) begin
                n_err++;
                $display("FAIL write_count d=%0d: got %0d want %0d", d, writes, good ? len : 0);
            end
            n_vec++;
            if (pkt_cnt !== e_pkt) begin
                n_err++;
                $display("FAIL pkt_cnt: got %0d want %0d", pkt_cnt, e_pkt);
            end
            n_vec++;
            if (drop_cnt !== e_drop) begin
                n_err++;
                $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, e_drop);
            end
            n_vec++;
            if (in_ready !== 1'b1 || sw_en !== 1'b0) begin
                n_err++;
                $display("FAIL idle_after_frame: got ready=%b sw_en=%b want ready=1 sw_en=0", in_ready, sw_en);
            end
        end
    endtask

    task automatic test_reset();
        in_valid  = 1'b1;
        in_data   = 8'h02;
        port_free = 4'hF;
        rst_n     = 1'b0;
        m_pkt     = 16'd0;
        m_drop    = 16'd0;
        #12;
        n_vec++;
        if (in_ready !== 1'b1 || sw_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_handshake: got ready=%b sw_en=%b want ready=1 sw_en=0", in_ready, sw_en);
        end
        n_vec++;
        if (port_addr !== 8'd0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_regs: got addr=%0d pkt=%0d drop=%0d want 0 0 0", port_addr, pkt_cnt, drop_cnt);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_basic();
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        send_frame(8'd2, 3, 999, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) pay[i] = 8'h10 + 8'(i);
        send_frame(8'd1, 4, 999, 1'b0, 1);
    endtask

    task automatic test_drop();
        pay[0] = 8'h5A; pay[1] = 8'hA5;
        send_frame(8'd7, 2, 999, 1'b0, -1);
        send_frame(8'd4, 0, 999, 1'b0, -1);
        pay[0] = 8'h11; pay[1] = 8'h22;
        send_frame(8'd3, 2, 999, 1'b0, -1);
    endtask

    task automatic test_zero_len();
        send_frame(8'd0, 0, 999, 1'b0, -1);
        pay[0] = 8'h77;
        send_frame(8'd0, 1, 999, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) pay[i] = 8'(i * 3 + 1);
        send_frame(8'd2, 5, 3, 1'b0, -1);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        port_free = 4'hF;
        rst_n     = 1'b0;
        #1;
        m_pkt  = 16'd0;
        m_drop = 16'd0;
        n_vec++;
        if (in_ready !== 1'b1 || sw_en !== 1'b0 || port_addr !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid: got ready=%b sw_en=%b addr=%0d want 1 0 0", in_ready, sw_en, port_addr);
        end
        n_vec++;
        if (pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid_cnt: got pkt=%0d drop=%0d want 0 0", pkt_cnt, drop_cnt);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        pay[0]   = 8'h55;
        send_frame(8'd3, 1, 999, 1'b0, -1);
    endtask

    task automatic test_long();
        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
        send_frame(8'd3, 255, 999, 1'b1, -1);
        send_frame(8'd255, 255, 999, 1'b1, -1);
    endtask

    task automatic test_random();
        logic [7:0] d;
        int         len;
        for (int f = 0; f < 60; f++) begin
            d   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            len = $urandom_range(0, 7);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            send_frame(d, len, 999, 1'b1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        port_free = 4'hF;
        rst_n     = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_zero_len();
        test_reset_mid();
        test_long();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
